// File: rtl/mem_stage_dm_if.sv
// ----------------------------------------------------------------------------
// mem_stage_dm_if
//   Request/response bundle between the M-stage pipeline logic and the
//   M-stage data memory.
//
//   master : pipeline side  - drives the access request, receives load data
//            and the fault flags.
//   slave  : memory side    - the mirror image.
//
//   mem_write  1   store request this cycle
//   mem_read   1   load request this cycle
//   mem_op     3   size/extension code (word, half zu/sx, byte zu/sx)
//   addr       32  byte address
//   wdata      32  store data; low half/byte used for sh/sb
//   pc         32  PC of the M-stage instruction (store trace only)
//   rdata      32  extended load data
//   misalign   1   access not aligned to its size
//   out_range  1   address beyond the end of the array
// ----------------------------------------------------------------------------
interface mem_stage_dm_if;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  mem_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic [31:0] rdata;
   logic        misalign;
   logic        out_range;

   modport master (
      output mem_write, mem_read, mem_op, addr, wdata, pc,
      input  rdata, misalign, out_range
   );

   modport slave (
      input  mem_write, mem_read, mem_op, addr, wdata, pc,
      output rdata, misalign, out_range
   );
endinterface

// File: rtl/mem_stage_dm.sv
// ----------------------------------------------------------------------------
// mem_stage_dm
//   M-stage data memory of the 5-stage MIPS pipeline. Word/half/byte stores
//   with byte-lane merge, zero/sign-extended loads with zero read latency,
//   and misalignment / out-of-range flagging.
//
//   clk    in   posedge clock
//   reset  in   synchronous, active-high; clears the whole array
//   bus    slave modport of mem_stage_dm_if (request in, load data + flags out)
//
//   DEPTH_WORDS  number of 32-bit words (power of 2)
//   AW           log2(DEPTH_WORDS), word-index width
// ----------------------------------------------------------------------------
module mem_stage_dm #(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = 12
) (
   input  logic          clk,
   input  logic          reset,
   mem_stage_dm_if.slave bus
);

   // mem_op encodings; 101..111 fall through to word
   localparam logic [2:0] OP_HU = 3'b001;
   localparam logic [2:0] OP_HS = 3'b010;
   localparam logic [2:0] OP_BU = 3'b011;
   localparam logic [2:0] OP_BS = 3'b100;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          is_half, is_byte, is_word, sext;
   logic          req, aligned, misalign, out_range, commit;
   logic [AW-1:0] word_idx;
   logic [31:0]   cur_word;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic [31:0]   merged_d;
   logic [31:0]   shifted;
   logic [31:0]   load_ext;
   logic          rd_ok;

   // ---------------------------------------------------------------- decode
   always_comb begin
      is_half = (bus.mem_op == OP_HU) || (bus.mem_op == OP_HS);
      is_byte = (bus.mem_op == OP_BU) || (bus.mem_op == OP_BS);
      is_word = !is_half && !is_byte;
      sext    = (bus.mem_op == OP_HS) || (bus.mem_op == OP_BS);
   end

   assign req      = bus.mem_read | bus.mem_write;
   assign aligned  = is_byte
                   | (is_half & ~bus.addr[0])
                   | (is_word & (bus.addr[1:0] == 2'b00));
   // Flags are forced low while reset is held.
   assign misalign  = ~reset & req & ~aligned;
   // Any set bit above the array's byte range means out of range.
   assign out_range = ~reset & req & (|bus.addr[31:AW+2]);

   assign word_idx = bus.addr[AW+1:2];
   assign cur_word = mem_q[word_idx];

   // ---------------------------------------------------------------- store merge
   // Store data is replicated across all lanes so the byte enables alone
   // select which lanes of the current word get replaced.
   always_comb begin
      be    = 4'b1111;
      wlane = bus.wdata;
      if (is_half) begin
         be    = bus.addr[1] ? 4'b1100 : 4'b0011;
         wlane = {2{bus.wdata[15:0]}};
      end else if (is_byte) begin
         be    = 4'b0001 << bus.addr[1:0];
         wlane = {4{bus.wdata[7:0]}};
      end
   end

   always_comb begin
      merged_d = cur_word;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) merged_d[8*k +: 8] = wlane[8*k +: 8];
      end
   end

   assign commit = bus.mem_write & ~reset & ~misalign & ~out_range;

   // ---------------------------------------------------------------- load path
   // Reads see the pre-edge array contents, so a same-cycle store to the
   // same word returns old data; the new value shows up next cycle.
   always_comb begin
      shifted  = cur_word;
      load_ext = cur_word;
      if (is_half) begin
         shifted  = cur_word >> {bus.addr[1], 4'b0000};
         load_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      end else if (is_byte) begin
         shifted  = cur_word >> {bus.addr[1:0], 3'b000};
         load_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
   end

   assign rd_ok         = ~reset & bus.mem_read & ~misalign & ~out_range;
   assign bus.rdata     = rd_ok ? load_ext : 32'h0;
   assign bus.misalign  = misalign;
   assign bus.out_range = out_range;

   // ---------------------------------------------------------------- array
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
      end else if (commit) begin
         mem_q[word_idx] <= merged_d;
      end
   end

`ifndef SYNTHESIS
   // Store trace: one line per committed store, full merged word.
   always_ff @(posedge clk) begin
      if (commit)
         $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, merged_d);
   end
`endif

endmodule
